cdc_handshake_receiver: RTL

CDC_HANDSHAKE_RECEIVER -- requirements
Module: cdc_handshake_receiver

---
 rtl/cdc_handshake_receiver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cdc_handshake_receiver.sv
// Receive side of a toggle-request / toggle-acknowledge CDC handshake.
// Detects a request, waits for the data to settle, captures the word, then returns an ack once the word is consumed.
`timescale 1ns/1ps
module cdc_handshake_receiver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 req_sync,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 ack,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 proto_err
);

  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SC_W-1:0] SC_LOAD = (SETTLE_CYCLES == 0) ? '0 : SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 req_seen_q, req_seen_d;
  logic [SC_W-1:0]      cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 req_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    data_d     = data_q;
    valid_d    = valid_q;
    count_d    = count_q;
    err_d      = err_q;
    req_edge   = (req_sync != req_seen_q);

    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (req_edge) begin
            req_seen_d = req_sync;
            if (SETTLE_CYCLES == 0) begin
              data_d  = data_in;
              valid_d = 1'b1;
              state_d = HOLD;
            end else begin
              cnt_d   = SC_LOAD;
              state_d = SETTLE;
            end
          end
        end
        // A request edge here is a sender violation: flag it, keep req_seen so it is retried from IDLE.
        SETTLE: begin
          if (req_edge) err_d = 1'b1;
          if (cnt_q == '0) begin
            data_d  = data_in;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (req_edge) err_d = 1'b1;
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            ack_d   = ~ack_q;
            count_d = count_q + 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign xfer_count = count_q;
  assign proto_err  = err_q;

endmodule
